// File: rtl/gf16_pkg.sv
// Shared types and constants for the GF(2^16) sequential reducer.
package gf16_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int PROD_W = 31;
  localparam int ELEM_W = 16;
  localparam int DEG    = 16;

  // Low 16 coefficients of x^16 + x^12 + x^3 + x + 1; the x^16 term is implicit.
  localparam logic [ELEM_W-1:0] POLY_DEF = 16'h100B;

  // Number of REDUCE cycles needed to clear the 15 high-order product bits.
  function automatic int calc_cyc(input int step);
    return (PROD_W - DEG + step - 1) / step;
  endfunction

endpackage

// File: rtl/gf16_reduce_step.sv
// One reduction slice: clears up to STEP product bits from position i_hi
// downward by conditionally XOR-ing the shifted modulus into the work value.
module gf16_reduce_step
  import gf16_pkg::*;
#(
  parameter int                STEP = 4,
  parameter logic [ELEM_W-1:0] POLY = POLY_DEF
) (
  input  logic [PROD_W-1:0] i_work,
  input  logic [4:0]        i_hi,
  output logic [PROD_W-1:0] o_work
);

  localparam logic [PROD_W-1:0] MODULUS = {{(PROD_W-DEG-1){1'b0}}, 1'b1, POLY};

  logic [PROD_W-1:0] w_work;
  logic [4:0]        w_pos;

  // Descending XOR chain; each lower position sees the updates made above it.
  always_comb begin
    w_work = i_work;
    w_pos  = i_hi;
    for (int k = 0; k < STEP; k++) begin
      w_pos = i_hi - 5'(k);
      if (int'(i_hi) >= DEG + k) begin
        if (w_work[w_pos]) begin
          w_work = w_work ^ (MODULUS << (w_pos - 5'(DEG)));
        end
      end
    end
    o_work = w_work;
  end

endmodule

// File: rtl/gf16_reduce_seq.sv
// Iterative reduction of a 31-bit carry-less product modulo x^16 + POLY,
// with valid/ready handshakes on both sides and data-independent latency.
module gf16_reduce_seq
  import gf16_pkg::*;
#(
  parameter logic [ELEM_W-1:0] POLY = POLY_DEF,
  parameter int                STEP = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PROD_W-1:0]   in_prod,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ELEM_W-1:0]   out_elem,
  output logic                busy
);

  localparam int CYC = calc_cyc(STEP);

  state_t              r_state;
  state_t              w_next_state;
  logic [PROD_W-1:0]   r_work;
  logic [3:0]          r_cnt;
  logic [ELEM_W-1:0]   r_out;
  logic [4:0]          w_hi;
  logic                w_last;
  logic [PROD_W-1:0]   w_step_work;

  // Highest bit handled this cycle; never drops below the field degree.
  function automatic logic [4:0] hi_pos(input logic [3:0] cnt);
    int h;
    h = (PROD_W - 1) - STEP * int'(cnt);
    if (h < DEG) h = DEG;
    return 5'(h);
  endfunction

  assign w_hi   = hi_pos(r_cnt);
  assign w_last = (r_cnt == 4'(CYC - 1));

  gf16_reduce_step #(
    .STEP (STEP),
    .POLY (POLY)
  ) u_step (
    .i_work (r_work),
    .i_hi   (w_hi),
    .o_work (w_step_work)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next_state = REDUCE;
      REDUCE:  if (w_last)    w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default:                w_next_state = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE:    in_ready  = 1'b1;
      REDUCE:  busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  // Work register, step counter and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work <= in_prod;
            r_cnt  <= '0;
          end
        end
        REDUCE: begin
          r_work <= w_step_work;
          r_cnt  <= r_cnt + 4'd1;
          if (w_last) r_out <= w_step_work[ELEM_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign out_elem = r_out;

  // A finished reduction must leave no coefficient at or above x^16.
  always_ff @(posedge clk) begin
    if (!rst && r_state == DONE) begin
      assert (r_work[PROD_W-1:DEG] == '0);
    end
  end

endmodule

// File: tb/tb_gf16_reduce_seq.sv
// Self-checking bench for gf16_reduce_seq: directed table, reset and
// backpressure sequences, deep fold at several STEP values, random regression.
module tb_gf16_reduce_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [30:0] in_prod;
  logic [15:0] out_elem;

  logic        a_in_valid, a_in_ready, a_out_valid, a_busy;
  logic [15:0] a_out_elem;
  logic        b_in_valid, b_in_ready, b_out_valid, b_busy;
  logic [15:0] b_out_elem;
  logic [30:0] deep_prod;
  logic        side_ready;

  gf16_reduce_seq #(.POLY(16'h100B), .STEP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .out_valid(out_valid), .out_ready(out_ready),
    .out_elem(out_elem), .busy(busy)
  );

  gf16_reduce_seq #(.POLY(16'h100B), .STEP(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_prod(deep_prod), .out_valid(a_out_valid), .out_ready(side_ready),
    .out_elem(a_out_elem), .busy(a_busy)
  );

  gf16_reduce_seq #(.POLY(16'h100B), .STEP(15)) dut_s15 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_prod(deep_prod), .out_valid(b_out_valid), .out_ready(side_ready),
    .out_elem(b_out_elem), .busy(b_busy)
  );

  localparam int CYC_MAIN = 4;

  typedef struct {
    logic [15:0] elem;
    int          acc;
  } exp_t;

  typedef struct {
    logic [30:0] prod;
    logic [15:0] exp;
  } vec_t;

  exp_t sb[$];
  exp_t popped;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: Horner evaluation, multiplying by x and reducing one bit at a time.
  function automatic logic [15:0] ref_mod(input logic [30:0] p);
    logic [16:0] r;
    r = '0;
    for (int i = 30; i >= 0; i--) begin
      r = {r[15:0], 1'b0};
      if (r[16]) r = r ^ 17'h1100B;
      r[0] = r[0] ^ p[i];
    end
    return r[15:0];
  endfunction

  task automatic send(input logic [30:0] p, input logic [15:0] e);
    exp_t x;
    bit   ok;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("send_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_valid = 1'b1;
      in_prod  = p;
      @(posedge clk);
      #1;
      x.elem = e;
      x.acc  = cyc;
      sb.push_back(x);
      in_valid = 1'b0;
    end
  endtask

  // Output monitor: latency on each rising out_valid, value on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        check("invariant_hi_zero", 32'(dut.r_work[30:16]), 32'd0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got elem %0h, required no output", out_elem);
        end else begin
          if (!prev_valid) check("latency", 32'(cyc - sb[0].acc), 32'(CYC_MAIN));
          if (out_ready) begin
            popped = sb.pop_front();
            check("elem", 32'(out_elem), 32'(popped.elem));
          end
        end
      end
      prev_valid = out_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  vec_t        tbl[7];
  int          lat_a, lat_b, acc;
  logic [15:0] ea, eb, held;
  logic [31:0] r32;
  logic [30:0] p;
  bit          seen;

  initial begin
    tbl[0] = '{31'h0000_1234, 16'h1234};
    tbl[1] = '{31'h0001_0000, 16'h100B};
    tbl[2] = '{31'h0002_0000, 16'h2016};
    tbl[3] = '{31'h1000_0000, 16'hABBB};
    tbl[4] = '{31'h0000_0000, 16'h0000};
    tbl[5] = '{31'h0000_8000, 16'h8000};
    tbl[6] = '{31'h0011_0000, 16'h00B0};

    rst = 1'b1; in_valid = 1'b0; in_prod = '0; out_ready = 1'b1;
    a_in_valid = 1'b0; b_in_valid = 1'b0; deep_prod = '0; side_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_elem", 32'(out_elem), 32'd0);
    rst = 1'b0;

    // Reset while a reduction is in flight: the operation must vanish.
    @(negedge clk);
    in_valid = 1'b1; in_prod = 31'h1000_0000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_output_after_rst", 32'(seen), 32'd0);

    // Directed vectors through the scoreboard.
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(tbl[i].prod, tbl[i].exp);
    for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
    check("table_drain", 32'(sb.size()), 32'd0);

    // Deep fold at STEP=1 and STEP=15 side by side.
    @(negedge clk);
    deep_prod = 31'h1000_0000; a_in_valid = 1'b1; b_in_valid = 1'b1;
    @(posedge clk);
    #1 acc = cyc; a_in_valid = 1'b0; b_in_valid = 1'b0;
    lat_a = -1; lat_b = -1; ea = '0; eb = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (a_out_valid && lat_a < 0) begin lat_a = cyc - acc; ea = a_out_elem; end
      if (b_out_valid && lat_b < 0) begin lat_b = cyc - acc; eb = b_out_elem; end
    end
    check("s1_latency", 32'(lat_a), 32'd15);
    check("s1_elem", 32'(ea), 32'hABBB);
    check("s15_latency", 32'(lat_b), 32'd1);
    check("s15_elem", 32'(eb), 32'hABBB);

    // Backpressure: result held, input blocked, stray in_valid ignored.
    out_ready = 1'b0;
    send(31'h5ABC_D012, ref_mod(31'h5ABC_D012));
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("bp_valid_rise", 32'(out_valid), 32'd1);
    held = out_elem;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_stable", 32'(out_elem), 32'(held));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      in_valid = (k % 2 == 0);
      r32 = $urandom();
      in_prod = r32[30:0];
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("bp_no_stray_accept", 32'(busy), 32'd0);

    // Random regression against the reference model.
    for (int n = 0; n < 10000; n++) begin
      r32 = $urandom();
      p = r32[30:0];
      send(p, ref_mod(p));
    end
    for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
    check("random_drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
